// File: rtl/reg_write_arbiter_if.sv
// Bus between N requesters and the shared-register arbiter.
//
// Handshake: req[i] is a level-sensitive "valid" that requester i holds,
// together with its wdata slice, until it sees gnt[i]. gnt[i] acts as the
// one-cycle "ready": the write is committed at the end of the cycle in
// which gnt[i] is high, using the wdata slice presented in that cycle.
// Requesters should drop req[i] after gnt[i]. A request left high is
// arbitrated again. q and wr_done report the committed result.
interface reg_write_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 4
);
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] wdata;
  logic [N-1:0]       gnt;
  logic [WIDTH-1:0]   q;
  logic               busy;
  logic               wr_done;

  // Requester side.
  modport master (
    output req, wdata,
    input  gnt, q, busy, wr_done
  );

  // Arbiter side.
  modport slave (
    input  req, wdata,
    output gnt, q, busy, wr_done
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter in front of one shared WIDTH-bit register.
// IDLE picks a winner starting at ptr. WRITE lasts one cycle and commits
// the winner's data at its closing edge.
// Optional feature macro: REG_WRITE_LOCK_EN. It adds a lock input. When
// lock is high during WRITE, ptr stays on the current winner so that the
// winner can burst.
module reg_write_arbiter #(
  parameter int               N         = 4,
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = 'h4
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef REG_WRITE_LOCK_EN
  input  logic                   lock,
`endif
  reg_write_arbiter_if.slave     bus,
  output logic                   dbg_state
);
  localparam int PW = $clog2(N);

  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    winner_q, winner_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             found;
  logic [PW-1:0]    pick;
  logic [WIDTH-1:0] wsel;
  logic [PW-1:0]    ptr_next;

  // Round-robin search: the first set req bit at or after ptr, wrapping modulo N.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Select the latched winner's data slice, sampled live during WRITE.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < N; i++) begin
      if (winner_q == PW'(i)) wsel = bus.wdata[i*WIDTH +: WIDTH];
    end
  end

  // Pointer after a write: advance past the winner, or hold it when locked.
  always_comb begin
    ptr_next = (winner_q == PW'(N-1)) ? '0 : winner_q + PW'(1);
`ifdef REG_WRITE_LOCK_EN
    if (lock) ptr_next = winner_q;
`endif
  end

  // Next-state logic. gnt, busy and wr_done are computed here and registered.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    data_d   = data_q;
    gnt_d    = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          winner_d = pick;
          gnt_d    = {{(N-1){1'b0}}, 1'b1} << pick;
          busy_d   = 1'b1;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        data_d  = wsel;
        done_d  = 1'b1;
        ptr_d   = ptr_next;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All state is registered. Reset wins over any in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      gnt_q    <= '0;
      data_q   <= RESET_VAL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      gnt_q    <= gnt_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.q       = data_q;
  assign bus.busy    = busy_q;
  assign bus.wr_done = done_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed testbench for reg_write_arbiter with N=4 and WIDTH=4. Each
// expected value is worked out by hand from the round-robin rules.
module tb_reg_write_arbiter;
  logic clk;
  logic rst;
  logic lock;
  logic dbg_state;
  int   vectors;
  int   errors;

  reg_write_arbiter_if #(.N(4), .WIDTH(4)) bus ();

  reg_write_arbiter #(.N(4), .WIDTH(4), .RESET_VAL(4'h4)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef REG_WRITE_LOCK_EN
    .lock      (lock),
`endif
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so that outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors   = 0;
    errors    = 0;
    lock      = 1'b0;
    rst       = 1'b1;
    bus.req   = 4'b1111;
    bus.wdata = 16'h4321;

    // Reset held for two cycles while every requester is asking.
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_q", bus.q, 4'h4);
      chk("rst_gnt", bus.gnt, 4'b0000);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.wr_done, 1'b0);
    end
    rst = 1'b0;

    // Fairness: all requesters held high. Grants go 0,1,2,3,0 and q goes 1,2,3,4,1.
    for (int k = 0; k < 5; k++) begin
      step();
      chk("fair_gnt", bus.gnt, 4'b0001 << (k % 4));
      chk("fair_busy", bus.busy, 1'b1);
      chk("fair_state", dbg_state, 1'b1);
      chk("fair_done_low", bus.wr_done, 1'b0);
      step();
      chk("fair_q", bus.q, (k % 4) + 1);
      chk("fair_done", bus.wr_done, 1'b1);
      chk("fair_gnt_off", bus.gnt, 4'b0000);
      chk("fair_busy_off", bus.busy, 1'b0);
    end

    // Single request from requester 2. ptr is 1 at this point.
    bus.req = 4'b0100;
    bus.wdata[11:8] = 4'hA;
    step();
    chk("single_gnt", bus.gnt, 4'b0100);
    chk("single_busy", bus.busy, 1'b1);
    chk("single_q_hold", bus.q, 4'h1);
    bus.req = 4'b0000;
    step();
    chk("single_q", bus.q, 4'hA);
    chk("single_done", bus.wr_done, 1'b1);
    chk("single_busy_off", bus.busy, 1'b0);
    step();
    chk("single_done_drop", bus.wr_done, 1'b0);
    chk("single_idle_gnt", bus.gnt, 4'b0000);
    chk("single_idle_q", bus.q, 4'hA);

    // Wrap: ptr is 3 after the grant to 2, so requester 3 wins ahead of 0.
    bus.req = 4'b1001;
    bus.wdata[15:12] = 4'h7;
    bus.wdata[3:0] = 4'h8;
    step();
    chk("wrap_gnt3", bus.gnt, 4'b1000);
    bus.req = 4'b0001;
    step();
    chk("wrap_q7", bus.q, 4'h7);
    step();
    chk("wrap_gnt0", bus.gnt, 4'b0001);
    bus.req = 4'b0000;
    step();
    chk("wrap_q8", bus.q, 4'h8);

    // Data changes and req is withdrawn during WRITE. The write still uses the new data.
    bus.req = 4'b0010;
    bus.wdata[7:4] = 4'h5;
    step();
    chk("late_gnt", bus.gnt, 4'b0010);
    bus.wdata[7:4] = 4'hA;
    bus.req = 4'b0000;
    step();
    chk("late_q", bus.q, 4'hA);
    chk("late_done", bus.wr_done, 1'b1);

    // Reset in the middle of a transaction: no write and no wr_done pulse.
    bus.req = 4'b0100;
    bus.wdata[11:8] = 4'h3;
    step();
    chk("midrst_gnt", bus.gnt, 4'b0100);
    rst = 1'b1;
    bus.req = 4'b0000;
    step();
    chk("midrst_q", bus.q, 4'h4);
    chk("midrst_gnt_off", bus.gnt, 4'b0000);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.wr_done, 1'b0);
    rst = 1'b0;
    step();
    chk("midrst_no_done", bus.wr_done, 1'b0);
    chk("midrst_q_hold", bus.q, 4'h4);

    // ptr was cleared by reset, so the first grant goes to requester 0.
    bus.req = 4'b1111;
    step();
    chk("post_rst_gnt", bus.gnt, 4'b0001);
    bus.req = 4'b0000;
    step();
    chk("post_rst_q", bus.q, 4'h8);

    // ptr is 1 here. Requesters 0 and 1 are held high.
    bus.req = 4'b0011;
    step();
    chk("pair_gnt1", bus.gnt, 4'b0010);
`ifdef REG_WRITE_LOCK_EN
    step();
    chk("lock_q_a", bus.q, 4'hA);
    step();
    chk("lock_gnt0", bus.gnt, 4'b0001);
    lock = 1'b1;
    step();
    chk("lock_q_8", bus.q, 4'h8);
    step();
    chk("lock_gnt0_again", bus.gnt, 4'b0001);
    step();
    step();
    chk("lock_gnt0_third", bus.gnt, 4'b0001);
    lock = 1'b0;
    bus.req = 4'b0000;
    step();
    chk("lock_done", bus.wr_done, 1'b1);
`else
    step();
    chk("pair_q_a", bus.q, 4'hA);
    step();
    chk("pair_gnt0", bus.gnt, 4'b0001);
    step();
    chk("pair_q_8", bus.q, 4'h8);
    step();
    chk("pair_gnt1_again", bus.gnt, 4'b0010);
    bus.req = 4'b0000;
    step();
    chk("pair_done", bus.wr_done, 1'b1);
`endif

    // Final report.
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit storage register between N requesters.
- Each requester presents write data plus a request. The arbiter picks one winner per transaction, acknowledges it with a one-cycle grant and commits that winner's data into the shared register.
- The block sits in front of any shared state register, so that multiple sources never drive the same register in the same cycle.

Parameters:
- N, 4, number of requesters (2..8).
- WIDTH, 4, width of the shared register and of each requester's data.
- RESET_VAL, 4'h4, value loaded into q on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- req  input  N  per-requester write request, level; bit i belongs to requester i.
- wdata  input  N*WIDTH  flattened write data; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  output  N  registered one-hot grant, high for exactly one cycle per transaction.
- q  output  WIDTH  registered shared-register contents.
- busy  output  1  high while a transaction is in the WRITE state.
- wr_done  output  1  one-cycle pulse in the cycle after q takes new data.

Behaviour:
- Single clock; reset is synchronous, active-high (rst).
- Reset (priority over everything, including mid-transaction):
  - state=IDLE, q=RESET_VAL, gnt=0, busy=0, wr_done=0, ptr=0, winner=0.
  - No pending write survives reset.
- FSM states: IDLE, WRITE.
- IDLE:
  - If req==0: stay in IDLE; gnt=0, busy=0.
  - Otherwise search req in the order ptr, ptr+1, ..., N-1, 0, ..., ptr-1; the first set bit is the winner k.
  - At the clock edge: winner<=k, gnt<=onehot(k), busy<=1, state<=WRITE.
- WRITE (always exactly one cycle):
  - gnt=onehot(winner), busy=1.
  - At the clock edge:
    - q <= wdata slice of winner, sampled during this cycle.
    - wr_done<=1, gnt<=0, busy<=0, ptr<=(winner+1) mod N, state<=IDLE.
- Transaction timing:
  - 2 cycles from req sampled in IDLE to q updated.
  - Maximum throughput is one write every 2 cycles.
- Once a winner is latched, a change of req during WRITE does not affect that write: no abort, and the data is still sampled.
- wr_done is high for exactly the one cycle after the WRITE edge (the IDLE cycle), then drops to 0 unless another WRITE completes.
- Requesters drop req after seeing gnt. A requester that keeps req high is re-arbitrated; round-robin order guarantees every other pending requester is served before it wins again.
- ptr wrap: after a grant to requester N-1, ptr=0.
- q changes only at the edge ending a WRITE state, or on reset.
- Pure register semantics: all state updates use non-blocking assignment, with no combinational path from req or wdata to q.

Optional Feature:
- Macro: REG_WRITE_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit).
  - If lock=1 during WRITE, ptr is not advanced (ptr<=winner). A still-requesting winner therefore wins the next arbitration, allowing a burst of writes.
  - lock is ignored in IDLE.
- When undefined: no lock port; ptr always advances as described under Behaviour.

Test Plan (N=4, WIDTH=4):
- Reset: assert rst 2 cycles with req=4'b1111 -> q=4'h4, gnt=0, busy=0, wr_done=0 throughout; first grant after rst drops goes to requester 0.
- Single request: req=4'b0100, wdata[2]=4'hA, drop req after gnt -> gnt=4'b0100 in cycle 2, q=4'hA and wr_done=1 in cycle 3, busy high only in cycle 2.
- Fairness: req=4'b1111 held, wdata slices 1,2,3,4 -> grant order 0,1,2,3,0 on every other cycle; q sequence 1,2,3,4,1.
- Wrap: ptr=3 after grant to 2, req=4'b1001 -> requester 3 wins, then requester 0.
- Data change during WRITE: wdata[winner] changes from 5 to 10 during the WRITE cycle -> q=10. Req withdrawn during WRITE -> write still happens.
- Reset mid-transaction: assert rst during WRITE -> q returns to 4'h4, no wr_done pulse. With REG_WRITE_LOCK_EN, lock=1 and req=4'b0011 -> requester 0 wins consecutively.
